// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM states, owner
// codes and the grant-priority rule.
package mem_arbiter_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } arb_owner_e;

   // Data normally wins; after a data grant a waiting fetch goes first.
   function automatic arb_owner_e pick_owner(input logic if_p, input logic d_p,
                                             input logic last_d);
      if (d_p && (!if_p || !last_d)) return OWN_D;
      return OWN_IF;
   endfunction

endpackage

// File: rtl/mem_arbiter_lat_cnt.sv
// Access-length down-counter: loaded at grant, counts down through BUSY and
// saturates at zero.
module arb_lat_cnt
   import mem_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && (r_cnt != '0))
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data stage) arbiter in front of a
// single-port memory with a fixed MEM_LAT-cycle access.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
);

   localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MEM_LAT - 1);

   arb_state_e  r_state, w_next;
   arb_owner_e  r_owner, w_gnt_own;
   logic        r_last_d;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_if_rdata, r_d_rdata;
   logic        r_we;
   logic        w_grant, w_if_p, w_d_p, w_zero, w_busy, w_done;

   assign w_busy = (r_state == ST_BUSY);
   assign w_done = (r_state == ST_DONE);

   arb_lat_cnt u_lat_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_grant),
      .i_load_val (LAT_LD),
      .i_dec      (w_busy),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_if_p    = 1'b0;
      w_d_p     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_if_p = if_req;
            w_d_p  = d_req;
         end
         ST_BUSY: begin
            if (w_zero) w_next = ST_DONE;
         end
         ST_DONE: begin
            // The requester being acked this cycle cannot be regranted yet.
            w_if_p = if_req && (r_owner != OWN_IF);
            w_d_p  = d_req  && (r_owner != OWN_D);
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      w_gnt_own = pick_owner(w_if_p, w_d_p, r_last_d);
      if (w_if_p || w_d_p) begin
         w_grant = 1'b1;
         w_next  = ST_BUSY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner    <= OWN_IF;
         r_last_d   <= 1'b0;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         if (w_grant) begin
            r_owner  <= w_gnt_own;
            r_last_d <= (w_gnt_own == OWN_D);
            if (w_gnt_own == OWN_D) begin
               r_addr  <= d_addr;
               r_we    <= d_we;
               r_wdata <= d_wdata;
            end else begin
               r_addr  <= if_addr;
               r_we    <= 1'b0;
               r_wdata <= '0;
            end
         end
         if (w_busy && w_zero) begin
            if (r_owner == OWN_IF)
               r_if_rdata <= mem_rdata;
            else if (!r_we)
               r_d_rdata <= mem_rdata;
         end
      end
   end

   assign mem_en    = w_busy;
   assign mem_we    = w_busy && r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign if_ack    = w_done && (r_owner == OWN_IF);
   assign d_ack     = w_done && (r_owner == OWN_D);
   assign stall     = (if_req && !if_ack) || (d_req && !d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model (grant time, access age, captured data).
module tb_mem_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_ack, d_ack, mem_en, mem_we, stall;

   logic        if_req1, d_req1, d_we1;
   logic [31:0] if_addr1, d_addr1, d_wdata1, mem_rdata1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
   logic        if_ack1, d_ack1, mem_en1, mem_we1, stall1;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
      .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_rdata(d_rdata1), .d_ack(d_ack1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1)
   );

   int nvec = 0;
   int nerr = 0;

   // model: one transaction in flight, aged in cycles since its grant
   bit          inflt, own_d, m_we, last_d;
   int          age;
   logic [31:0] m_addr, m_wdata, m_ir, m_dr;
   bit          grants[$];
   bit          last_iack, last_dack;
   logic        s_en, s_we;
   logic [31:0] s_addr;
   int          cnum = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      assert (act === exp) else begin
         nerr++;
         $error("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      inflt = 0; own_d = 0; m_we = 0; last_d = 0; age = 0;
      m_addr = '0; m_wdata = '0; m_ir = '0; m_dr = '0;
   endtask

   task automatic cyc();
      logic e_busy, e_done, e_iack, e_dack, pi, pd, gd;
      @(negedge clk);
      e_done = inflt && (age == LAT + 1);
      e_busy = inflt && (age >= 1) && (age <= LAT);
      e_iack = e_done && !own_d;
      e_dack = e_done && own_d;
      s_en = mem_en; s_we = mem_we; s_addr = mem_addr;
      chk("mem_en", 32'(mem_en), 32'(e_busy));
      chk("if_ack", 32'(if_ack), 32'(e_iack));
      chk("d_ack", 32'(d_ack), 32'(e_dack));
      chk("stall", 32'(stall), 32'((if_req && !e_iack) || (d_req && !e_dack)));
      chk("if_rdata", if_rdata, m_ir);
      chk("d_rdata", d_rdata, m_dr);
      if (e_busy) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", 32'(mem_we), 32'(m_we));
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      last_iack = e_iack;
      last_dack = e_dack;
      cnum++;
      @(posedge clk);
      if (e_busy && age == LAT) begin
         if (!own_d) m_ir = mem_rdata;
         else if (!m_we) m_dr = mem_rdata;
      end
      pi = if_req && !(e_done && !own_d);
      pd = d_req && !(e_done && own_d);
      if ((!inflt || e_done) && (pi || pd)) begin
         gd = pd && (!pi || !last_d);
         own_d = gd; last_d = gd;
         m_addr = gd ? d_addr : if_addr;
         m_we = gd && d_we;
         m_wdata = d_wdata;
         inflt = 1; age = 1;
         grants.push_back(gd);
      end else if (e_done) inflt = 0;
      else if (inflt) age++;
      #1;
   endtask

   task automatic drain(input string tag);
      bit ok = 0;
      for (int k = 0; k < 80 && !ok; k++) begin
         cyc();
         if (last_iack) if_req = 0;
         if (last_dack) d_req = 0;
         ok = !inflt && !if_req && !d_req;
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic rnd_drive();
      if (!if_req) begin
         if ($urandom_range(3) == 0) begin if_req = 1; if_addr = $urandom; end
      end else if (last_iack) begin
         if_req = ($urandom_range(1) == 1); if_addr = $urandom;
      end else if (inflt && !own_d && age <= LAT && $urandom_range(9) == 0)
         if_req = 0;
      if (!d_req) begin
         if ($urandom_range(2) == 0) begin
            d_req = 1; d_addr = $urandom; d_wdata = $urandom; d_we = ($urandom_range(1) == 1);
         end
      end else if (last_dack) begin
         d_req = ($urandom_range(1) == 1); d_addr = $urandom; d_wdata = $urandom;
         d_we = ($urandom_range(1) == 1);
      end else if (inflt && own_d && age <= LAT && $urandom_range(9) == 0)
         d_req = 0;
      mem_rdata = $urandom;
   endtask

   initial begin
      int en_cnt, cd, ci, acks;
      bit got, seen, fw, en_after;
      logic [31:0] fa;

      rst = 1;
      if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      if_req1 = 0; if_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
      mem_rdata1 = '0;
      model_reset();
      #12;
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_if_ack", 32'(if_ack), 0);
      chk("rst_d_ack", 32'(d_ack), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      @(posedge clk); #1 rst = 0;

      // MEM_LAT=1 read: one BUSY cycle, ack two cycles after the grant
      d_req1 = 1; d_we1 = 0; d_addr1 = 32'h20; mem_rdata1 = 32'h1357_2468;
      @(negedge clk);
      chk("l1_grant_en", 32'(mem_en1), 0);
      chk("l1_grant_stall", 32'(stall1), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("l1_busy_en", 32'(mem_en1), 1);
      chk("l1_busy_addr", mem_addr1, 32'h20);
      chk("l1_busy_we", 32'(mem_we1), 0);
      chk("l1_busy_ack", 32'(d_ack1), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("l1_done_ack", 32'(d_ack1), 1);
      chk("l1_done_en", 32'(mem_en1), 0);
      chk("l1_done_rdata", d_rdata1, 32'h1357_2468);
      @(posedge clk); #1 d_req1 = 0;
      @(negedge clk);
      chk("l1_after_ack", 32'(d_ack1), 0);
      chk("l1_after_stall", 32'(stall1), 0);
      @(posedge clk); #1;

      // single fetch
      mem_rdata = 32'h2002_0005; if_req = 1; if_addr = 32'h40;
      en_cnt = 0; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc();
         if (s_en) en_cnt++;
         if (last_iack) got = 1;
      end
      if_req = 0;
      chk("t41_ack_seen", 32'(got), 1);
      chk("t41_en_cycles", 32'(en_cnt), 2);
      chk("t41_if_rdata", if_rdata, 32'h2002_0005);
      #1 chk("t41_stall_after", 32'(stall), 0);
      drain("t41_drain");

      // simultaneous requests: data first, then fetch straight from DONE
      d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
      if_req = 1; if_addr = 32'h80;
      grants.delete(); cd = -1; ci = -1; seen = 0; fa = '0; fw = 0; en_after = 0;
      for (int k = 0; k < 20 && ci < 0; k++) begin
         cyc();
         if (s_en && !seen) begin seen = 1; fa = s_addr; fw = s_we; end
         if (cd >= 0 && cnum == cd + 1) en_after = s_en;
         if (last_dack) begin cd = cnum; d_req = 0; end
         if (last_iack) begin ci = cnum; if_req = 0; end
      end
      chk("t42_first_addr", fa, 32'h10);
      chk("t42_first_we", 32'(fw), 1);
      chk("t42_grants", 32'(grants.size()), 2);
      if (grants.size() >= 2) begin
         chk("t42_grant0_d", 32'(grants[0]), 1);
         chk("t42_grant1_i", 32'(grants[1]), 0);
      end
      chk("t42_no_idle", 32'(en_after), 1);
      chk("t42_if_lat", 32'(ci - cd), LAT + 1);
      drain("t42_drain");

      // back-to-back data with fetch held: D, I, D
      grants.delete();
      if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
      for (int k = 0; k < 40 && grants.size() < 3; k++) begin
         mem_rdata = $urandom;
         cyc();
         if (last_dack) d_addr = d_addr + 4;
         if (last_iack) if_addr = if_addr + 4;
      end
      chk("t43_grants", 32'(grants.size()), 3);
      if (grants.size() >= 3) begin
         chk("t43_g0", 32'(grants[0]), 1);
         chk("t43_g1", 32'(grants[1]), 0);
         chk("t43_g2", 32'(grants[2]), 1);
      end
      drain("t43_drain");

      // data read dropped mid-BUSY still completes once
      d_req = 1; d_we = 0; d_addr = 32'h46; mem_rdata = 32'hCAFE_0046;
      cyc();
      cyc();
      d_req = 0;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         if (last_dack) acks++;
      end
      chk("t46_acks", 32'(acks), 1);
      chk("t46_d_rdata", d_rdata, 32'hCAFE_0046);
      chk("t46_idle_en", 32'(s_en), 0);

      // reset in the second BUSY cycle aborts; held fetch then completes
      if_req = 1; if_addr = 32'h444; mem_rdata = 32'h4545_4545;
      cyc();
      cyc();
      #3 rst = 1;
      #1;
      chk("t45_mem_en", 32'(mem_en), 0);
      chk("t45_if_ack", 32'(if_ack), 0);
      chk("t45_d_ack", 32'(d_ack), 0);
      chk("t45_mem_addr", mem_addr, 0);
      chk("t45_if_rdata", if_rdata, 0);
      model_reset();
      @(posedge clk); #1 rst = 0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc();
         if (last_iack) got = 1;
      end
      if_req = 0;
      chk("t45_ack_seen", 32'(got), 1);
      chk("t45_if_rdata_final", if_rdata, 32'h4545_4545);
      drain("t45_drain");

      // random traffic
      for (int k = 0; k < 400; k++) begin
         rnd_drive();
         cyc();
      end
      drain("rnd_drain");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32: address width.
REQ-002 Parameter DATA_W, 32: data width.
REQ-003 Parameter MEM_LAT, 2: memory access length in cycles; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 if_req  input  1  instruction fetch request; held until if_ack.
REQ-007 if_addr  input  ADDR_W  fetch address; stable while if_req high.
REQ-008 if_rdata  output  DATA_W  fetched word; valid while if_ack high.
REQ-009 if_ack  output  1  one-cycle fetch completion pulse.
REQ-010 d_req  input  1  data-stage request; held until d_ack.
REQ-011 d_we  input  1  data write (1) / read (0).
REQ-012 d_addr  input  ADDR_W  data address; stable while d_req high.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_rdata  output  DATA_W  load result; valid while d_ack high after a read.
REQ-015 d_ack  output  1  one-cycle data completion pulse.
REQ-016 mem_en  output  1  single-port memory enable.
REQ-017 mem_we  output  1  memory write strobe.
REQ-018 mem_addr  output  ADDR_W  memory address.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_rdata  input  DATA_W  memory read data; valid in the final BUSY cycle.
REQ-021 stall  output  1  pipeline stall = (if_req & ~if_ack) | (d_req & ~d_ack).

Function
REQ-022 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-023 In IDLE with a pending request, the block SHALL grant it, latch addr/we/wdata and the owner into registers, load the counter with MEM_LAT-1, and go to BUSY.
REQ-024 When both requests are pending at a grant, data SHALL win unless the previous grant was data; in that case fetch wins (round-robin after a data grant).
REQ-025 In BUSY, mem_en SHALL be 1 and mem_addr/mem_wdata SHALL come from the latched registers.
REQ-026 In BUSY, mem_we SHALL equal the latched we, and SHALL be 0 for fetch grants.
REQ-027 The counter SHALL decrement each BUSY cycle; at 0, mem_rdata SHALL be registered into the owner's rdata register and the FSM goes to DONE.
REQ-028 With MEM_LAT=1, BUSY SHALL last exactly one cycle.
REQ-029 In DONE, the owner's ack SHALL be 1 for exactly that cycle; mem_en SHALL be 0.
REQ-030 Latency from grant cycle to ack SHALL be MEM_LAT+1 cycles.
REQ-031 In DONE, the acked requester's req SHALL be ignored; a pending request from the other requester SHALL be granted directly (DONE->BUSY), otherwise DONE->IDLE.
REQ-032 A req dropped during BUSY SHALL NOT abort the access; the ack is still pulsed.
REQ-033 On a write ack, d_rdata SHALL hold its previous value.
REQ-034 if_rdata/d_rdata SHALL retain their values until the next completion for that owner.
REQ-035 if_ack and d_ack SHALL never be 1 in the same cycle.

Reset
REQ-036 rst SHALL immediately force IDLE, counter 0, and last-grant = fetch.
REQ-037 rst SHALL force mem_en, mem_we, if_ack and d_ack to 0, and mem_addr, mem_wdata, if_rdata and d_rdata to 0.
REQ-038 rst during BUSY SHALL abort the access with no ack; after release, pending requests are re-arbitrated from IDLE.

Structure
REQ-039 State encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and owner codes SHALL live in a shared definitions include used by the datapath.
REQ-040 The latency down-counter SHALL be a sub-module arb_lat_cnt (load, dec, zero flag, 4-bit).

Verification
REQ-041 MEM_LAT=2, if_req with if_addr=0x0000_0040, mem_rdata=0x2002_0005 -> mem_en high for 2 cycles, then if_ack=1 with if_rdata=0x2002_0005; stall low the cycle after.
REQ-042 if_req and d_req rise together, d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF -> data granted first (mem_we=1, mem_addr=0x10), d_ack, then DONE->BUSY fetch with no IDLE cycle, then if_ack.
REQ-043 Back-to-back d_req with if_req held -> grant order D, I, D; fetch is not starved.
REQ-044 MEM_LAT=1, read of d_addr=0x20 -> BUSY 1 cycle, d_ack 2 cycles after the grant cycle, d_rdata = mem_rdata.
REQ-045 rst asserted in the 2nd BUSY cycle -> mem_en=0 in the same cycle, no ack; after release the held if_req completes normally.
REQ-046 d_req dropped mid-BUSY -> the access completes, d_ack pulses once, and the FSM returns to IDLE.
